// File: rtl/agc_timepulse_seq.sv
// ---------------------------------------------------------------------------
// agc_timepulse_seq
//
// Timepulse sequencer for the NOR-gate timing/control datapath. Splits the
// clock into NPULSE one-hot timepulses (T01..T12), each PHASES clocks long,
// and marks the end of every memory cycle time (MCT). Supports monitor stop,
// single-step and GOJAM restart.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous reset, active low
//   stop_req   monitor stop request (level, sampled at the MCT boundary)
//   step       single-step request (rising edge acts while halted)
//   gojam      synchronous restart, active high
//   tp         one-hot timepulse, tp[0] = T01; all zero while halted
//   phase      phase index within the current timepulse
//   mct_end    high during the last clock of T12
//   stopped    high while halted
//   mct_count  completed-MCT count, wraps modulo 2^MCT_W
//
// PHASES must lie in 1..8 so that the phase index fits in 3 bits.
// ---------------------------------------------------------------------------
module agc_timepulse_seq #(
    parameter int NPULSE = 12,
    parameter int PHASES = 2,
    parameter int MCT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stop_req,
    input  logic              step,
    input  logic              gojam,
    output logic [NPULSE-1:0] tp,
    output logic [2:0]        phase,
    output logic              mct_end,
    output logic              stopped,
    output logic [MCT_W-1:0]  mct_count
);

    localparam int PW = (NPULSE > 1) ? $clog2(NPULSE) : 1;
    localparam logic [PW-1:0] LAST_PULSE = PW'(NPULSE - 1);
    localparam logic [2:0]    LAST_PHASE = 3'(PHASES - 1);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t           state_q, state_n;
    logic [PW-1:0]    pulse_q, pulse_n;
    logic [2:0]       phase_q, phase_n;
    logic [MCT_W-1:0] count_q, count_n;
    logic             step_q;
    logic             step_edge;
    logic             boundary;

    // A step only counts on its rising edge, so a held button cannot fire
    // more than one MCT.
    assign step_edge = step & ~step_q;

    // Boundary cycle: last phase of the last pulse while running.
    assign boundary = (state_q == RUN) && (pulse_q == LAST_PULSE)
                      && (phase_q == LAST_PHASE);

    // Next-state logic. gojam overrides stop and step, and because it is
    // checked first it also suppresses the boundary increment and the
    // stop_req sample when it lands on the boundary cycle.
    always_comb begin
        state_n = state_q;
        pulse_n = pulse_q;
        phase_n = phase_q;
        count_n = count_q;
        if (gojam) begin
            state_n = RUN;
            pulse_n = '0;
            phase_n = '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (phase_q == LAST_PHASE) begin
                        phase_n = '0;
                        if (pulse_q == LAST_PULSE) begin
                            pulse_n = '0;
                            count_n = count_q + 1'b1;
                            if (stop_req) begin
                                state_n = HALT;
                            end
                        end else begin
                            pulse_n = pulse_q + 1'b1;
                        end
                    end else begin
                        phase_n = phase_q + 3'd1;
                    end
                end
                HALT: begin
                    pulse_n = '0;
                    phase_n = '0;
                    if (!stop_req || step_edge) begin
                        state_n = RUN;
                    end
                end
                default: begin
                    state_n = RUN;
                    pulse_n = '0;
                    phase_n = '0;
                end
            endcase
        end
    end

    // State register. The step history register is cleared by reset so that
    // a step held through reset release is seen as a fresh edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= RUN;
            pulse_q <= '0;
            phase_q <= '0;
            count_q <= '0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            pulse_q <= pulse_n;
            phase_q <= phase_n;
            count_q <= count_n;
            step_q  <= step;
        end
    end

    // Outputs decode registered state only, so no input reaches an output
    // combinationally.
    always_comb begin
        tp = '0;
        if (state_q == RUN) begin
            tp = NPULSE'(1) << pulse_q;
        end
    end

    assign phase     = (state_q == RUN) ? phase_q : 3'd0;
    assign mct_end   = boundary;
    assign stopped   = (state_q == HALT);
    assign mct_count = count_q;

endmodule

// File: tb/tb_agc_timepulse_seq.sv
// ---------------------------------------------------------------------------
// tb_agc_timepulse_seq
//
// Directed bench for agc_timepulse_seq with NPULSE=12, PHASES=2 and a 4-bit
// MCT counter so that wraparound is reachable quickly. Inputs change and
// outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_agc_timepulse_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        stop_req;
    logic        step;
    logic        gojam;
    logic [11:0] tp;
    logic [2:0]  phase;
    logic        mct_end;
    logic        stopped;
    logic [3:0]  mct_count;

    int          checks = 0;
    int          fails  = 0;
    logic [11:0] exp_tp;
    logic [2:0]  exp_ph;
    logic        exp_end;

    agc_timepulse_seq #(
        .NPULSE(12),
        .PHASES(2),
        .MCT_W (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .stop_req (stop_req),
        .step     (step),
        .gojam    (gojam),
        .tp       (tp),
        .phase    (phase),
        .mct_end  (mct_end),
        .stopped  (stopped),
        .mct_count(mct_count)
    );

    // 10 time-unit clock
    always #5 clk = ~clk;

    // Advance one full clock; inputs set before this are sampled at the
    // rising edge in between.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b0; stop_req = 1'b0; step = 1'b0; gojam = 1'b0;
        tick(2);
        checks++; if (tp !== 12'h001) begin fails++; $display("[TB] FAIL reset_tp: got %h expected %h", tp, 12'h001); end
        checks++; if (phase !== 3'd0) begin fails++; $display("[TB] FAIL reset_phase: got %0d expected 0", phase); end
        checks++; if (stopped !== 1'b0) begin fails++; $display("[TB] FAIL reset_stopped: got %b expected 0", stopped); end
        checks++; if (mct_end !== 1'b0) begin fails++; $display("[TB] FAIL reset_mct_end: got %b expected 0", mct_end); end
        checks++; if (mct_count !== 4'd0) begin fails++; $display("[TB] FAIL reset_count: got %0d expected 0", mct_count); end
        rst = 1'b1;
    endtask

    task automatic test_run_sequence;
        for (int c = 0; c < 24; c++) begin
            exp_tp  = 12'h001 << (c / 2);
            exp_ph  = 3'(c % 2);
            exp_end = (c == 23);
            checks++;
            if ({tp, phase, mct_end} !== {exp_tp, exp_ph, exp_end}) begin
                fails++;
                $display("[TB] FAIL run_seq cycle %0d: got tp=%h ph=%0d end=%b expected tp=%h ph=%0d end=%b",
                         c, tp, phase, mct_end, exp_tp, exp_ph, exp_end);
            end
            tick();
        end
        checks++; if (mct_count !== 4'd1) begin fails++; $display("[TB] FAIL run_count: got %0d expected 1", mct_count); end
        checks++; if (tp !== 12'h001) begin fails++; $display("[TB] FAIL run_wrap_tp: got %h expected 001", tp); end
    endtask

    task automatic test_stop;
        // stop pulse that falls before the boundary is ignored
        tick(4);
        stop_req = 1'b1;
        tick(10);
        stop_req = 1'b0;
        tick(10);
        checks++; if (stopped !== 1'b0 || tp !== 12'h001) begin fails++; $display("[TB] FAIL stop_early_pulse: got stopped=%b tp=%h expected stopped=0 tp=001", stopped, tp); end
        checks++; if (mct_count !== 4'd2) begin fails++; $display("[TB] FAIL stop_early_count: got %0d expected 2", mct_count); end
        // stop raised during T05 takes effect after T12
        tick(8);
        checks++; if (tp !== 12'h010) begin fails++; $display("[TB] FAIL stop_t05: got %h expected 010", tp); end
        stop_req = 1'b1;
        tick(15);
        checks++; if (tp !== 12'h800 || mct_end !== 1'b1) begin fails++; $display("[TB] FAIL stop_boundary: got tp=%h end=%b expected tp=800 end=1", tp, mct_end); end
        tick();
        checks++; if ({stopped, tp, phase} !== {1'b1, 12'h000, 3'd0}) begin fails++; $display("[TB] FAIL stop_halt: got stopped=%b tp=%h ph=%0d expected stopped=1 tp=000 ph=0", stopped, tp, phase); end
        checks++; if (mct_count !== 4'd3) begin fails++; $display("[TB] FAIL stop_count: got %0d expected 3", mct_count); end
        tick(3);
        checks++; if (stopped !== 1'b1 || tp !== 12'h000) begin fails++; $display("[TB] FAIL stop_hold: got stopped=%b tp=%h expected stopped=1 tp=000", stopped, tp); end
        stop_req = 1'b0;
        tick();
        checks++; if ({stopped, tp, phase} !== {1'b0, 12'h001, 3'd0}) begin fails++; $display("[TB] FAIL stop_resume: got stopped=%b tp=%h ph=%0d expected stopped=0 tp=001 ph=0", stopped, tp, phase); end
    endtask

    task automatic test_step;
        stop_req = 1'b1;
        tick(24);
        checks++; if (stopped !== 1'b1 || mct_count !== 4'd4) begin fails++; $display("[TB] FAIL step_pre_halt: got stopped=%b count=%0d expected stopped=1 count=4", stopped, mct_count); end
        step = 1'b1;
        tick();
        for (int c = 0; c < 24; c++) begin
            exp_tp = 12'h001 << (c / 2);
            exp_ph = 3'(c % 2);
            checks++;
            if ({stopped, tp, phase} !== {1'b0, exp_tp, exp_ph}) begin
                fails++;
                $display("[TB] FAIL step_run cycle %0d: got stopped=%b tp=%h ph=%0d expected stopped=0 tp=%h ph=%0d",
                         c, stopped, tp, phase, exp_tp, exp_ph);
            end
            if (c == 5)  step = 1'b0;
            if (c == 10) step = 1'b1;
            tick();
        end
        checks++; if (stopped !== 1'b1 || mct_count !== 4'd5) begin fails++; $display("[TB] FAIL step_rehalt: got stopped=%b count=%0d expected stopped=1 count=5", stopped, mct_count); end
        tick(3);
        checks++; if (stopped !== 1'b1 || tp !== 12'h000) begin fails++; $display("[TB] FAIL step_no_retrigger: got stopped=%b tp=%h expected stopped=1 tp=000", stopped, tp); end
        step = 1'b0;
        tick();
        checks++; if (stopped !== 1'b1) begin fails++; $display("[TB] FAIL step_low_halt: got stopped=%b expected 1", stopped); end
        step = 1'b1;
        tick();
        checks++; if ({stopped, tp, phase} !== {1'b0, 12'h001, 3'd0}) begin fails++; $display("[TB] FAIL step_fresh_edge: got stopped=%b tp=%h ph=%0d expected stopped=0 tp=001 ph=0", stopped, tp, phase); end
        step = 1'b0;
        stop_req = 1'b0;
    endtask

    task automatic test_gojam;
        tick(13);
        checks++; if (tp !== 12'h040 || phase !== 3'd1) begin fails++; $display("[TB] FAIL gojam_pre: got tp=%h ph=%0d expected tp=040 ph=1", tp, phase); end
        gojam = 1'b1;
        tick();
        gojam = 1'b0;
        checks++; if ({tp, phase, mct_end} !== {12'h001, 3'd0, 1'b0}) begin fails++; $display("[TB] FAIL gojam_restart: got tp=%h ph=%0d end=%b expected tp=001 ph=0 end=0", tp, phase, mct_end); end
        checks++; if (mct_count !== 4'd5) begin fails++; $display("[TB] FAIL gojam_count: got %0d expected 5", mct_count); end
        for (int c = 0; c < 24; c++) begin
            exp_end = (c == 23);
            checks++;
            if (mct_end !== exp_end) begin
                fails++;
                $display("[TB] FAIL gojam_mct_end cycle %0d: got %b expected %b", c, mct_end, exp_end);
            end
            tick();
        end
        checks++; if (mct_count !== 4'd6) begin fails++; $display("[TB] FAIL gojam_after_count: got %0d expected 6", mct_count); end
        gojam = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (tp !== 12'h001 || phase !== 3'd0) begin
                fails++;
                $display("[TB] FAIL gojam_held %0d: got tp=%h ph=%0d expected tp=001 ph=0", i, tp, phase);
            end
        end
        gojam = 1'b0;
        stop_req = 1'b1;
        tick(24);
        checks++; if (stopped !== 1'b1 || mct_count !== 4'd7) begin fails++; $display("[TB] FAIL gojam_pre_halt: got stopped=%b count=%0d expected stopped=1 count=7", stopped, mct_count); end
        gojam = 1'b1;
        tick();
        gojam = 1'b0;
        stop_req = 1'b0;
        checks++; if ({stopped, tp, mct_count} !== {1'b0, 12'h001, 4'd7}) begin fails++; $display("[TB] FAIL gojam_from_halt: got stopped=%b tp=%h count=%0d expected stopped=0 tp=001 count=7", stopped, tp, mct_count); end
    endtask

    task automatic test_wrap;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int m = 1; m <= 16; m++) begin
            tick(24);
            checks++;
            if (mct_count !== 4'(m % 16)) begin
                fails++;
                $display("[TB] FAIL wrap_count mct %0d: got %0d expected %0d", m, mct_count, m % 16);
            end
        end
        tick(23);
        checks++; if (mct_end !== 1'b1) begin fails++; $display("[TB] FAIL wrap_boundary: got %b expected 1", mct_end); end
        gojam = 1'b1;
        stop_req = 1'b1;
        tick();
        gojam = 1'b0;
        stop_req = 1'b0;
        checks++; if (mct_count !== 4'd0) begin fails++; $display("[TB] FAIL gojam_in_b_count: got %0d expected 0", mct_count); end
        checks++; if ({stopped, tp, mct_end} !== {1'b0, 12'h001, 1'b0}) begin fails++; $display("[TB] FAIL gojam_in_b_state: got stopped=%b tp=%h end=%b expected stopped=0 tp=001 end=0", stopped, tp, mct_end); end
    endtask

    task automatic test_reset_priority;
        stop_req = 1'b1;
        tick(24);
        checks++; if (stopped !== 1'b1 || mct_count !== 4'd1) begin fails++; $display("[TB] FAIL rstpri_pre: got stopped=%b count=%0d expected stopped=1 count=1", stopped, mct_count); end
        rst = 1'b0;
        gojam = 1'b1;
        tick();
        rst = 1'b1;
        gojam = 1'b0;
        checks++; if ({stopped, tp, phase, mct_count} !== {1'b0, 12'h001, 3'd0, 4'd0}) begin fails++; $display("[TB] FAIL rstpri_halted: got stopped=%b tp=%h ph=%0d count=%0d expected stopped=0 tp=001 ph=0 count=0", stopped, tp, phase, mct_count); end
        stop_req = 1'b0;
        tick(24);
        tick(17);
        checks++; if ({tp, phase, mct_count} !== {12'h100, 3'd1, 4'd1}) begin fails++; $display("[TB] FAIL rstpri_mid_t09: got tp=%h ph=%0d count=%0d expected tp=100 ph=1 count=1", tp, phase, mct_count); end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        checks++; if ({stopped, tp, phase, mct_count} !== {1'b0, 12'h001, 3'd0, 4'd0}) begin fails++; $display("[TB] FAIL rstpri_running: got stopped=%b tp=%h ph=%0d count=%0d expected stopped=0 tp=001 ph=0 count=0", stopped, tp, phase, mct_count); end
    endtask

    initial begin
        rst = 1'b0; stop_req = 1'b0; step = 1'b0; gojam = 1'b0;
        test_reset;
        test_run_sequence;
        test_stop;
        test_step;
        test_gojam;
        test_wrap;
        test_reset_priority;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
